morra_scoreboard: RTL and testbench

//  Downstream consumer of the MorraCinese FSMD. Samples INIZIA (fed to the game)

---
 rtl/morra_scoreboard_if.sv | 14 +
 rtl/morra_scoreboard.sv | 203 ++++++++++++++++++++
 tb/tb_morra_scoreboard.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/morra_scoreboard_if.sv
// morra_scoreboard_if
//   Result-log handshake between the scoreboard and its host/display.
//   res_valid : head of the result FIFO is valid (FIFO non-empty)
//   res_data  : {winner[1:0], rounds[4:0]} of the oldest logged match
//   res_ready : consumer takes the head when res_valid & res_ready
//   master = scoreboard side, slave = consumer side.
interface morra_scoreboard_if;
   logic       res_valid;
   logic [6:0] res_data;
   logic       res_ready;

   modport master (output res_valid, output res_data, input res_ready);
   modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/morra_scoreboard.sv
// morra_scoreboard
//   Watches INIZIA/MANCHE/PARTITA of a MorraCinese game, counts rounds of the
//   current game, keeps saturating match tallies since reset and logs every
//   finished match into a small first-word-fall-through result FIFO.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   INIZIA              : game restart strobe
//   MANCHE / PARTITA    : round / match result codes (01 P1, 10 P2, 11 draw)
//   p1/p2/draw_rounds   : per-game round counters (saturate at 31)
//   p1/p2/draw_matches  : match tallies (saturate at all-ones)
//   res                 : result FIFO handshake (master side)
//   log_ovf             : sticky, a result was dropped on a full FIFO
module morra_scoreboard #(
   parameter int CNT_W     = 8,
   parameter int LOG_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               INIZIA,
   input  logic [1:0]         MANCHE,
   input  logic [1:0]         PARTITA,
   output logic [4:0]         p1_rounds,
   output logic [4:0]         p2_rounds,
   output logic [4:0]         draw_rounds,
   output logic [CNT_W-1:0]   p1_matches,
   output logic [CNT_W-1:0]   p2_matches,
   output logic [CNT_W-1:0]   draw_matches,
   morra_scoreboard_if.master res,
   output logic               log_ovf
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);
   localparam logic [LOG_DEPTH:0]   CNT_ONE   = (LOG_DEPTH + 1)'(1);
   localparam logic [LOG_DEPTH:0]   CNT_FULL  = (LOG_DEPTH + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]     TALLY_ONE = CNT_W'(1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PLAYING = 2'd1;
   localparam logic [1:0] ENDED   = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [4:0]           p1_q, p1_d, p2_q, p2_d, dr_q, dr_d;
   logic [CNT_W-1:0]     p1m_q, p1m_d, p2m_q, p2m_d, drm_q, drm_d;
   logic [6:0]           mem_q [DEPTH];
   logic [6:0]           mem_d [DEPTH];
   logic [LOG_DEPTH-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LOG_DEPTH:0]   cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic [6:0]           data_q, data_d;
   logic                 ovf_q, ovf_d;
   logic                 push_s, push_ok_s, pop_s, full_s;
   logic [6:0]           sum_s;
   logic [4:0]           rounds_s;

   function automatic logic [4:0] inc_round(input logic [4:0] v);
      return (v == 5'd31) ? v : v + 5'd1;
   endfunction

   function automatic logic [CNT_W-1:0] inc_tally(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + TALLY_ONE;
   endfunction

   // Total rounds of the finishing game: pre-increment counts plus the final round.
   always_comb begin
      sum_s = {2'b00, p1_q} + {2'b00, p2_q} + {2'b00, dr_q}
            + {6'd0, (MANCHE != 2'b00)};
      if (sum_s > 7'd31) begin
         rounds_s = 5'd31;
      end else begin
         rounds_s = sum_s[4:0];
      end
   end

   // Game FSM, round counters and match tallies.
   always_comb begin
      state_d = state_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      dr_d    = dr_q;
      p1m_d   = p1m_q;
      p2m_d   = p2m_q;
      drm_d   = drm_q;
      push_s  = 1'b0;
      case (state_q)
         PLAYING: begin
            if (INIZIA) begin
               // Restart aborts the game: nothing logged or tallied.
               p1_d = 5'd0;
               p2_d = 5'd0;
               dr_d = 5'd0;
            end else begin
               case (MANCHE)
                  2'b01:   p1_d = inc_round(p1_q);
                  2'b10:   p2_d = inc_round(p2_q);
                  2'b11:   dr_d = inc_round(dr_q);
                  default: p1_d = p1_q;
               endcase
               if (PARTITA != 2'b00) begin
                  push_s  = 1'b1;
                  state_d = ENDED;
                  case (PARTITA)
                     2'b01:   p1m_d = inc_tally(p1m_q);
                     2'b10:   p2m_d = inc_tally(p2m_q);
                     default: drm_d = inc_tally(drm_q);
                  endcase
               end else begin
                  state_d = PLAYING;
               end
            end
         end
         IDLE, ENDED: begin
            if (INIZIA) begin
               state_d = PLAYING;
               p1_d    = 5'd0;
               p2_d    = 5'd0;
               dr_d    = 5'd0;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result FIFO: a full FIFO still accepts a push when the head leaves that cycle.
   always_comb begin
      mem_d     = mem_q;
      full_s    = (cnt_q == CNT_FULL);
      pop_s     = valid_q & res.res_ready;
      push_ok_s = push_s & (~full_s | pop_s);
      ovf_d     = ovf_q | (push_s & full_s & ~pop_s);
      wr_d      = wr_q;
      rd_d      = rd_q;
      if (push_ok_s) begin
         mem_d[wr_q] = {PARTITA, rounds_s};
         wr_d        = wr_q + PTR_ONE;
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + PTR_ONE;
      end else begin
         rd_d = rd_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      // Head is registered so res_valid/res_data come straight from flops.
      valid_d = (cnt_d != '0);
      data_d  = mem_d[rd_d];
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p1_q    <= 5'd0;
         p2_q    <= 5'd0;
         dr_q    <= 5'd0;
         p1m_q   <= '0;
         p2m_q   <= '0;
         drm_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= 7'd0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 7'd0;
         end
      end else begin
         state_q <= state_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         dr_q    <= dr_d;
         p1m_q   <= p1m_d;
         p2m_q   <= p2m_d;
         drm_q   <= drm_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         mem_q   <= mem_d;
      end
   end

   assign p1_rounds     = p1_q;
   assign p2_rounds     = p2_q;
   assign draw_rounds   = dr_q;
   assign p1_matches    = p1m_q;
   assign p2_matches    = p2m_q;
   assign draw_matches  = drm_q;
   assign res.res_valid = valid_q;
   assign res.res_data  = data_q;
   assign log_ovf       = ovf_q;

endmodule

// File: tb/tb_morra_scoreboard.sv
// tb_morra_scoreboard
//   Directed bench: a table of single-cycle vectors with hand-computed
//   expectations, followed by hand-written multi-cycle sequences
//   (FIFO overflow, full-with-pop, saturation, async reset).
module tb_morra_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       INIZIA;
   logic [1:0] MANCHE;
   logic [1:0] PARTITA;
   logic [4:0] p1_rounds, p2_rounds, draw_rounds;
   logic [7:0] p1_matches, p2_matches, draw_matches;
   logic       log_ovf;
   int         total_cnt;
   int         pass_cnt;

   morra_scoreboard_if rif ();

   morra_scoreboard #(.CNT_W(8), .LOG_DEPTH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .INIZIA       (INIZIA),
      .MANCHE       (MANCHE),
      .PARTITA      (PARTITA),
      .p1_rounds    (p1_rounds),
      .p2_rounds    (p2_rounds),
      .draw_rounds  (draw_rounds),
      .p1_matches   (p1_matches),
      .p2_matches   (p2_matches),
      .draw_matches (draw_matches),
      .res          (rif.master),
      .log_ovf      (log_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       inz;
      logic [1:0] m;
      logic [1:0] p;
      logic       rdy;
      int         p1, p2, dr, p1m, p2m, drm;
      logic       vld;
      logic [6:0] dat;
      logic       ovf;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic inz, input logic [1:0] m, input logic [1:0] p,
                      input logic rdy, input int p1, input int p2, input int dr,
                      input int p1m, input int p2m, input int drm,
                      input logic vld, input logic [6:0] dat, input logic ovf);
      vec_t v;
      v.inz = inz; v.m = m; v.p = p; v.rdy = rdy;
      v.p1 = p1; v.p2 = p2; v.dr = dr;
      v.p1m = p1m; v.p2m = p2m; v.drm = drm;
      v.vld = vld; v.dat = dat; v.ovf = ovf;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic inz, input logic [1:0] m, input logic [1:0] p,
                       input logic rdy);
      INIZIA        = inz;
      MANCHE        = m;
      PARTITA       = p;
      rif.res_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Play a complete game of n rounds all won by 'win'; the last round ends it.
   task automatic play(input logic [1:0] win, input int n, input logic rdy_last);
      step(1'b1, 2'b00, 2'b00, 1'b0);
      for (int r = 0; r < n - 1; r++) step(1'b0, win, 2'b00, 1'b0);
      step(1'b0, win, win, rdy_last);
   endtask

   initial begin
      total_cnt     = 0;
      pass_cnt      = 0;
      rst_n         = 1'b0;
      INIZIA        = 1'b0;
      MANCHE        = 2'b00;
      PARTITA       = 2'b00;
      rif.res_ready = 1'b0;

      //   inz  M      P      rdy   p1 p2 dr  p1m p2m drm  vld   dat     ovf
      add(1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b01, 2'b00, 1'b0, 1, 0, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 1, 1, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b00, 2'b00, 1'b0, 1, 1, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b01, 2'b00, 1'b0, 2, 1, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b1, 2'b01, 2'b00, 1'b0, 0, 0, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 0, 1, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 0, 2, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 0, 3, 0,  0, 0, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b01, 2'b10, 1'b0, 1, 3, 0,  0, 1, 0,  1'b1, 7'h44, 1'b0);
      add(1'b0, 2'b01, 2'b01, 1'b0, 1, 3, 0,  0, 1, 0,  1'b1, 7'h44, 1'b0);
      add(1'b1, 2'b00, 2'b00, 1'b1, 0, 0, 0,  0, 1, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b11, 2'b00, 1'b0, 0, 0, 1,  0, 1, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b11, 2'b00, 1'b0, 0, 0, 2,  0, 1, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b11, 2'b00, 1'b0, 0, 0, 3,  0, 1, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 0, 1, 3,  0, 1, 0,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b01, 2'b11, 1'b0, 1, 1, 3,  0, 1, 1,  1'b1, 7'h65, 1'b0);
      add(1'b0, 2'b00, 2'b00, 1'b1, 1, 1, 3,  0, 1, 1,  1'b0, 7'h00, 1'b0);
      add(1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0,  0, 1, 1,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b01, 2'b00, 1'b0, 1, 0, 0,  0, 1, 1,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 1, 1, 0,  0, 1, 1,  1'b0, 7'h00, 1'b0);
      add(1'b1, 2'b00, 2'b01, 1'b0, 0, 0, 0,  0, 1, 1,  1'b0, 7'h00, 1'b0);
      add(1'b0, 2'b01, 2'b01, 1'b0, 1, 0, 0,  1, 1, 1,  1'b1, 7'h21, 1'b0);
      add(1'b0, 2'b10, 2'b00, 1'b0, 1, 0, 0,  1, 1, 1,  1'b1, 7'h21, 1'b0);
      add(1'b0, 2'b11, 2'b10, 1'b0, 1, 0, 0,  1, 1, 1,  1'b1, 7'h21, 1'b0);
      add(1'b0, 2'b00, 2'b00, 1'b1, 1, 0, 0,  1, 1, 1,  1'b0, 7'h00, 1'b0);

      // Reset state while rst_n is held low.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(rif.res_valid), 0);
      chk("rst_p1m", int'(p1_matches), 0);
      chk("rst_ovf", int'(log_ovf), 0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         step(vt[i].inz, vt[i].m, vt[i].p, vt[i].rdy);
         chk($sformatf("v%0d_p1r", i), int'(p1_rounds), vt[i].p1);
         chk($sformatf("v%0d_p2r", i), int'(p2_rounds), vt[i].p2);
         chk($sformatf("v%0d_drr", i), int'(draw_rounds), vt[i].dr);
         chk($sformatf("v%0d_p1m", i), int'(p1_matches), vt[i].p1m);
         chk($sformatf("v%0d_p2m", i), int'(p2_matches), vt[i].p2m);
         chk($sformatf("v%0d_drm", i), int'(draw_matches), vt[i].drm);
         chk($sformatf("v%0d_vld", i), int'(rif.res_valid), int'(vt[i].vld));
         chk($sformatf("v%0d_ovf", i), int'(log_ovf), int'(vt[i].ovf));
         if (vt[i].vld) chk($sformatf("v%0d_dat", i), int'(rif.res_data), int'(vt[i].dat));
      end

      // Overflow: five matches with no consumer, the fifth is dropped.
      for (int k = 0; k < 5; k++) play(2'b01, k + 1, 1'b0);
      chk("ovf_valid", int'(rif.res_valid), 1);
      chk("ovf_flag", int'(log_ovf), 1);
      chk("ovf_p1m", int'(p1_matches), 6);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain1_vld%0d", k), int'(rif.res_valid), 1);
         chk($sformatf("drain1_dat%0d", k), int'(rif.res_data), {25'd0, 2'b01, 5'(k + 1)});
         step(1'b0, 2'b00, 2'b00, 1'b1);
      end
      chk("drain1_empty", int'(rif.res_valid), 0);

      // Full FIFO with a same-cycle pop accepts the new result.
      for (int k = 0; k < 4; k++) play(2'b10, k + 1, 1'b0);
      play(2'b11, 1, 1'b1);
      chk("fullpop_p2m", int'(p2_matches), 5);
      chk("fullpop_drm", int'(draw_matches), 2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain2_vld%0d", k), int'(rif.res_valid), 1);
         chk($sformatf("drain2_dat%0d", k), int'(rif.res_data),
             (k < 3) ? {25'd0, 2'b10, 5'(k + 2)} : 32'h61);
         step(1'b0, 2'b00, 2'b00, 1'b1);
      end
      chk("drain2_empty", int'(rif.res_valid), 0);

      // Round counter and logged round count saturate at 31.
      step(1'b1, 2'b00, 2'b00, 1'b0);
      for (int r = 0; r < 33; r++) step(1'b0, 2'b01, 2'b00, 1'b0);
      chk("sat_p1r", int'(p1_rounds), 31);
      step(1'b0, 2'b10, 2'b10, 1'b0);
      chk("sat_dat", int'(rif.res_data), 32'h5F);
      chk("sat_p2r", int'(p2_rounds), 1);
      chk("sat_p2m", int'(p2_matches), 6);

      // Match tally saturates at 255.
      for (int g = 0; g < 260; g++) play(2'b11, 1, 1'b1);
      chk("tally_sat", int'(draw_matches), 255);

      // Asynchronous reset with the FIFO non-empty clears everything at once.
      play(2'b01, 1, 1'b0);
      chk("prerst_valid", int'(rif.res_valid), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(rif.res_valid), 0);
      chk("arst_p1m", int'(p1_matches), 0);
      chk("arst_p2m", int'(p2_matches), 0);
      chk("arst_drm", int'(draw_matches), 0);
      chk("arst_ovf", int'(log_ovf), 0);
      chk("arst_p1r", int'(p1_rounds), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
